// File: rtl/demux4_stream.sv
// Registered 1-to-4 stream demultiplexer with static-select or round-robin burst routing.
// Optional DEMUX4_CLEAR_UNSEL_EN: outputs not receiving a beat are registered to 0 each cycle.
module demux4_stream_lane #(
  parameter int DATA_W    = 32,
  parameter bit CLR_UNSEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hit,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              vld
);
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      vld <= 1'b0;
    end else begin
      vld <= hit;
      if (hit)            q <= d;
      else if (CLR_UNSEL) q <= '0;
    end
  end
endmodule

module demux4_stream #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [DATA_W-1:0] in0,
  input  logic              in_valid,
  (* versat_latency = 1 *) output logic [DATA_W-1:0] out0,
  (* versat_latency = 1 *) output logic [DATA_W-1:0] out1,
  (* versat_latency = 1 *) output logic [DATA_W-1:0] out2,
  (* versat_latency = 1 *) output logic [DATA_W-1:0] out3,
  output logic [3:0]        out_valid,
  output logic              done,
  input  logic              mode,
  input  logic [1:0]        sel,
  input  logic [2:0]        num_outs,
  input  logic [15:0]       burst,
  input  logic [15:0]       len
);
`ifdef DEMUX4_CLEAR_UNSEL_EN
  localparam bit CLR_UNSEL = 1'b1;
`else
  localparam bit CLR_UNSEL = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t      state, state_n;
  logic        mode_q;
  logic [1:0]  sel_q, idx, idx_n;
  logic [2:0]  nouts_q;
  logic [15:0] burst_q, len_q, beat_cnt, beat_n, burst_cnt, bcnt_n;

  // Effective config: a run cycle uses the live (sanitised) inputs.
  logic        e_mode;
  logic [1:0]  e_sel, c_idx, route;
  logic [2:0]  e_nouts, nouts_s;
  logic [15:0] e_burst, e_len, burst_s, c_beat, c_bcnt;
  logic        act, accept;
  logic [3:0]  hit;

  always_comb begin
    nouts_s = (num_outs == 3'd0) ? 3'd1 : (num_outs > 3'd4) ? 3'd4 : num_outs;
    burst_s = (burst == 16'd0) ? 16'd1 : burst;
    e_mode  = run ? mode    : mode_q;
    e_sel   = run ? sel     : sel_q;
    e_nouts = run ? nouts_s : nouts_q;
    e_burst = run ? burst_s : burst_q;
    e_len   = run ? len     : len_q;
    c_idx   = run ? 2'd0    : idx;
    c_beat  = run ? 16'd0   : beat_cnt;
    c_bcnt  = run ? 16'd0   : burst_cnt;
    act     = run ? (len != 16'd0) : (state == ACTIVE);
    accept  = act && in_valid;
    route   = e_mode ? c_idx : e_sel;
    for (int k = 0; k < 4; k++) hit[k] = accept && (route == 2'(k));

    state_n = state;
    beat_n  = beat_cnt;
    bcnt_n  = burst_cnt;
    idx_n   = idx;
    if (run) begin
      state_n = (len == 16'd0) ? DONE : ACTIVE;
      beat_n  = '0;
      bcnt_n  = '0;
      idx_n   = '0;
    end
    if (accept) begin
      beat_n  = c_beat + 16'd1;
      state_n = (c_beat == e_len - 16'd1) ? DONE : ACTIVE;
      if (c_bcnt == e_burst - 16'd1) begin
        bcnt_n = '0;
        idx_n  = ({1'b0, c_idx} == e_nouts - 3'd1) ? 2'd0 : c_idx + 2'd1;
      end else begin
        bcnt_n = c_bcnt + 16'd1;
        idx_n  = c_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      burst_cnt <= '0;
      idx       <= '0;
      mode_q    <= 1'b0;
      sel_q     <= '0;
      nouts_q   <= 3'd1;
      burst_q   <= 16'd1;
      len_q     <= '0;
    end else begin
      state     <= state_n;
      beat_cnt  <= beat_n;
      burst_cnt <= bcnt_n;
      idx       <= idx_n;
      if (run) begin
        mode_q  <= mode;
        sel_q   <= sel;
        nouts_q <= nouts_s;
        burst_q <= burst_s;
        len_q   <= len;
      end
    end
  end

  assign done = (state == DONE);

  logic [3:0][DATA_W-1:0] q;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    demux4_stream_lane #(.DATA_W(DATA_W), .CLR_UNSEL(CLR_UNSEL)) u_lane (
      .clk (clk),
      .rst (rst),
      .hit (hit[k]),
      .d   (in0),
      .q   (q[k]),
      .vld (out_valid[k])
    );
  end

  assign out0 = q[0];
  assign out1 = q[1];
  assign out2 = q[2];
  assign out3 = q[3];
endmodule

// File: tb/tb_demux4_stream.sv
// Randomised and directed bench for demux4_stream against a beat-index routing model.
module tb_demux4_stream;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1, run = 1'b0, in_valid = 1'b0, mode = 1'b0;
  logic [DW-1:0] in0 = '0;
  logic [1:0]    sel = '0;
  logic [2:0]    num_outs = 3'd1;
  logic [15:0]   burst = 16'd1, len = 16'd0;
  logic [DW-1:0] out0, out1, out2, out3;
  logic [3:0]    out_valid;
  logic          done;

  always #5 clk = ~clk;

  demux4_stream #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .run(run), .in0(in0), .in_valid(in_valid),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out_valid(out_valid), .done(done),
    .mode(mode), .sel(sel), .num_outs(num_outs), .burst(burst), .len(len)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: destination of beat n is sel (mode 0) or (n / burst) % num_outs (mode 1).
  logic [31:0] m_out [4];
  logic [3:0]  m_vld;
  int m_st = 0;  // 0 idle, 1 active, 2 done
  int m_n = 0, c_mode = 0, c_sel = 0, c_nouts = 1, c_burst = 1, c_len = 0;

  task automatic cyc(input bit r, input bit rn, input bit v, input logic [31:0] d);
    int k;
    @(negedge clk);
    rst = r; run = rn; in_valid = v; in0 = d;
    m_vld = '0;
    if (r) begin
      for (int i = 0; i < 4; i++) m_out[i] = '0;
      m_st = 0;
      m_n  = 0;
    end else begin
      if (rn) begin
        c_mode  = int'(mode);
        c_sel   = int'(sel);
        c_nouts = (num_outs == 0) ? 1 : (num_outs > 4) ? 4 : int'(num_outs);
        c_burst = (burst == 0) ? 1 : int'(burst);
        c_len   = int'(len);
        m_n     = 0;
        m_st    = (len == 0) ? 2 : 1;
      end
      if (m_st == 1 && v) begin
        k = c_mode ? (m_n / c_burst) % c_nouts : c_sel;
        m_vld[k] = 1'b1;
        m_out[k] = d;
        m_n++;
        if (m_n == c_len) m_st = 2;
      end
`ifdef DEMUX4_CLEAR_UNSEL_EN
      for (int i = 0; i < 4; i++) if (!m_vld[i]) m_out[i] = '0;
`endif
    end
    @(posedge clk);
    #1;
    chk("out0", out0, m_out[0]);
    chk("out1", out1, m_out[1]);
    chk("out2", out2, m_out[2]);
    chk("out3", out3, m_out[3]);
    chk("out_valid", {28'b0, out_valid}, {28'b0, m_vld});
    chk("done", {31'b0, done}, {31'b0, m_st == 2});
  endtask

  task automatic cfg(input bit md, input logic [1:0] s, input logic [2:0] no,
                     input logic [15:0] b, input logic [15:0] l);
    mode = md; sel = s; num_outs = no; burst = b; len = l;
  endtask

  initial begin
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 32'h99);
    chk("rst_out_valid", {28'b0, out_valid}, 32'h0);

    // Abort mid-transfer with reset, then a stray beat must not emerge.
    cfg(1, 0, 3'd4, 16'd1, 16'd10);
    cyc(0, 1, 1, 32'h1);
    cyc(0, 0, 1, 32'h2);
    cyc(0, 0, 1, 32'h3);
    cyc(1, 0, 1, 32'h4);
    chk("rst_mid_out1", out1, 32'h0);
    chk("rst_mid_done", {31'b0, done}, 32'h0);
    cyc(0, 0, 1, 32'h55);
    chk("rst_no_vld", {28'b0, out_valid}, 32'h0);

    // Static select to out2.
    cfg(0, 2'd2, 3'd1, 16'd1, 16'd3);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 32'hA);
    chk("s_out2_a", out2, 32'hA);
    cyc(0, 0, 1, 32'hB);
    cyc(0, 0, 1, 32'hC);
    chk("s_out2_c", out2, 32'hC);
    chk("s_vld", {28'b0, out_valid}, 32'h4);
    chk("s_done", {31'b0, done}, 32'h1);
    chk("s_out0", out0, 32'h0);

    // Round-robin, 3 outputs, bursts of 2, 7 beats (run carries beat 1).
    cfg(1, 0, 3'd3, 16'd2, 16'd7);
    cyc(0, 1, 1, 32'd1);
    for (int i = 2; i <= 7; i++) cyc(0, 0, 1, 32'(i));
    chk("rr_out0_last", out0, 32'd7);
    chk("rr_out2", out2, 32'd6);
    chk("rr_done", {31'b0, done}, 32'h1);

    // Sanitised config: num_outs 0 and burst 0 act as 1, with a bubble.
    cfg(1, 0, 3'd0, 16'd0, 16'd2);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 32'd9);
    cyc(0, 0, 0, 32'hDEAD);
    cyc(0, 0, 1, 32'd8);
    chk("san_out0", out0, 32'd8);
    cyc(0, 0, 1, 32'h1234);

    // Re-run from DONE with a coincident beat.
    cfg(0, 2'd3, 3'd2, 16'd1, 16'd4);
    cyc(0, 1, 1, 32'h77);
    chk("rerun_out3", out3, 32'h77);
    chk("rerun_vld", {28'b0, out_valid}, 32'h8);
    chk("rerun_done", {31'b0, done}, 32'h0);

    // len = 0 goes straight to DONE and drops beats.
    cfg(1, 0, 3'd4, 16'd1, 16'd0);
    cyc(0, 1, 1, 32'h66);
    chk("len0_done", {31'b0, done}, 32'h1);
    cyc(0, 0, 1, 32'h67);
    chk("len0_vld", {28'b0, out_valid}, 32'h0);

    // Random traffic; config wiggles every cycle but only run latches it.
    for (int c = 0; c < 600; c++) begin
      cfg(1'($urandom), 2'($urandom), 3'($urandom), 16'($urandom_range(0, 3)),
          16'($urandom_range(0, 12)));
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6,
          $urandom_range(0, 99) < 70, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
